// File: rtl/keypad_pkg.sv
// -----------------------------------------------------------------------------
// keypad_pkg
//   Shared types and constants for the 4x4 matrix keypad scanner.
//   - kp_state_t     : scanner FSM states
//   - COL_STROBE     : column index -> active-low one-hot column strobe
//   - KEY_NONE       : key_code value before any key has been accepted
//   - lowest_low_row : picks the winning row when several rows read low
// -----------------------------------------------------------------------------
package keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;
  localparam int ROW_W    = 2;
  localparam int COL_W    = 2;
  localparam int CODE_W   = ROW_W + COL_W;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } kp_state_t;

  localparam logic [NUM_COLS-1:0] COL_STROBE [NUM_COLS] = '{
    4'b1110, 4'b1101, 4'b1011, 4'b0111
  };

  localparam logic [CODE_W-1:0] KEY_NONE = '0;

  // Lowest-index row that reads low wins; returns 0 when no row is low.
  function automatic logic [ROW_W-1:0] lowest_low_row(input logic [NUM_ROWS-1:0] rows_n);
    lowest_low_row = '0;
    for (int i = NUM_ROWS - 1; i >= 0; i--) begin
      if (!rows_n[i]) lowest_low_row = ROW_W'(i);
    end
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// -----------------------------------------------------------------------------
// scan_tick_gen
//   Free-running counter 0..OVERFLOW that wraps to 0. tick is high for the
//   single clk cycle in which the count equals OVERFLOW, giving one tick per
//   OVERFLOW+1 clocks.
// Ports:
//   clk   in  system clock
//   reset in  synchronous, active-high reset (count returns to 0)
//   tick  out one-cycle scan tick
// -----------------------------------------------------------------------------
module scan_tick_gen #(
  parameter int OVERFLOW = 65535
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int              CW   = (OVERFLOW < 1) ? 1 : $clog2(OVERFLOW + 1);
  localparam logic [CW-1:0]   LAST = CW'(OVERFLOW);

  logic [CW-1:0] r_count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (r_count == LAST) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

  assign tick = (r_count == LAST);

endmodule

// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
//   Scans a 4x4 matrix keypad. One column is strobed low at a time; the rows
//   are read back (active-low), synchronised, debounced on scan ticks, and an
//   accepted key is reported as a one-cycle key_valid pulse with
//   key_code = {row, col}. The column is frozen while a key is being debounced
//   or held, so the same key is watched until its release is accepted.
// Optional feature (macro KEYPAD_REPEAT_EN):
//   While held, key_valid re-pulses after REPEAT_DELAY low ticks and then every
//   REPEAT_PERIOD low ticks; any high sample restarts that schedule. The
//   REPEAT_* parameters exist only in that build.
// Ports:
//   clk        in   system clock
//   reset      in   synchronous, active-high reset
//   row_n      in   [3:0] keypad rows, active-low, asynchronous
//   col_select out  [3:0] active-low one-hot column strobe
//   key_code   out  [3:0] {row, col} of last accepted key, held until next accept
//   key_valid  out  one-cycle pulse when key_code is (re)issued
//   key_held   out  high from press accept until release accept
// -----------------------------------------------------------------------------
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_OVERFLOW  = 65535,
`ifdef KEYPAD_REPEAT_EN
  parameter int REPEAT_DELAY   = 64,
  parameter int REPEAT_PERIOD  = 16,
`endif
  parameter int DEBOUNCE_TICKS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row_n,
  output logic [3:0] col_select,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int               DEB_W      = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [DEB_W-1:0] DEB_TARGET = DEB_W'(DEBOUNCE_TICKS);

`ifdef KEYPAD_REPEAT_EN
  localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int HOLD_W   = $clog2(HOLD_MAX + 1);
  localparam logic [HOLD_W-1:0] REP_DELAY_C  = HOLD_W'(REPEAT_DELAY);
  localparam logic [HOLD_W-1:0] REP_PERIOD_C = HOLD_W'(REPEAT_PERIOD);
`endif

  logic                w_tick;
  logic [NUM_ROWS-1:0] r_row_meta;
  logic [NUM_ROWS-1:0] r_rows_s;

  kp_state_t           r_state,     w_state;
  logic [COL_W-1:0]    r_col,       w_col;
  logic [ROW_W-1:0]    r_row,       w_row;
  logic [DEB_W-1:0]    r_deb_cnt,   w_deb_cnt;
  logic [DEB_W-1:0]    r_rel_cnt,   w_rel_cnt;
  logic [CODE_W-1:0]   r_key_code,  w_key_code;
  logic                r_key_valid, w_key_valid;
  logic                r_key_held,  w_key_held;
  logic                w_row_low;
  logic                w_accept;
`ifdef KEYPAD_REPEAT_EN
  logic [HOLD_W-1:0]   r_hold_cnt,  w_hold_cnt;
  logic                r_repeating, w_repeating;
`endif

  scan_tick_gen #(
    .OVERFLOW (SCAN_OVERFLOW)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (w_tick)
  );

  // Two-flop synchroniser; resets to the idle (all rows high) level so no
  // phantom key is seen on the first ticks after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_row_meta <= '1;
      r_rows_s   <= '1;
    end else begin
      r_row_meta <= row_n;
      r_rows_s   <= r_row_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= SCAN;
      r_col       <= '0;
      r_row       <= '0;
      r_deb_cnt   <= '0;
      r_rel_cnt   <= '0;
      r_key_code  <= KEY_NONE;
      r_key_valid <= 1'b0;
      r_key_held  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      r_hold_cnt  <= '0;
      r_repeating <= 1'b0;
`endif
    end else begin
      r_state     <= w_state;
      r_col       <= w_col;
      r_row       <= w_row;
      r_deb_cnt   <= w_deb_cnt;
      r_rel_cnt   <= w_rel_cnt;
      r_key_code  <= w_key_code;
      r_key_valid <= w_key_valid;
      r_key_held  <= w_key_held;
`ifdef KEYPAD_REPEAT_EN
      r_hold_cnt  <= w_hold_cnt;
      r_repeating <= w_repeating;
`endif
    end
  end

  always_comb begin
    // NOTE: every variable gets a default before any branch so no path can
    // leave it unassigned and infer a latch.
    w_state     = r_state;
    w_col       = r_col;
    w_row       = r_row;
    w_deb_cnt   = r_deb_cnt;
    w_rel_cnt   = r_rel_cnt;
    w_key_code  = r_key_code;
    w_key_valid = 1'b0;
    w_key_held  = r_key_held;
    w_accept    = 1'b0;
    w_row_low   = ~r_rows_s[r_row];
`ifdef KEYPAD_REPEAT_EN
    w_hold_cnt  = r_hold_cnt;
    w_repeating = r_repeating;
`endif

    if (w_tick) begin
      unique case (r_state)
        SCAN: begin
          if (r_rows_s != '1) begin
            // Column stays put: the key just found is on the strobed column.
            w_row = lowest_low_row(r_rows_s);
            if (DEBOUNCE_TICKS == 1) begin
              w_accept = 1'b1;
            end else begin
              w_deb_cnt = DEB_W'(1);
              w_state   = DEBOUNCE;
            end
          end else begin
            w_col = r_col + 1'b1;
          end
        end

        DEBOUNCE: begin
          if (w_row_low) begin
            if (r_deb_cnt + 1'b1 == DEB_TARGET) begin
              w_accept = 1'b1;
            end else begin
              w_deb_cnt = r_deb_cnt + 1'b1;
            end
          end else begin
            w_deb_cnt = '0;
            w_col     = r_col + 1'b1;
            w_state   = SCAN;
          end
        end

        HELD: begin
          if (w_row_low) begin
            w_rel_cnt = '0;
`ifdef KEYPAD_REPEAT_EN
            if (r_hold_cnt + 1'b1 == (r_repeating ? REP_PERIOD_C : REP_DELAY_C)) begin
              w_key_valid = 1'b1;
              w_hold_cnt  = '0;
              w_repeating = 1'b1;
            end else begin
              w_hold_cnt  = r_hold_cnt + 1'b1;
            end
`endif
          end else begin
`ifdef KEYPAD_REPEAT_EN
            w_hold_cnt  = '0;
            w_repeating = 1'b0;
`endif
            if (r_rel_cnt + 1'b1 == DEB_TARGET) begin
              w_rel_cnt  = '0;
              w_key_held = 1'b0;
              w_col      = r_col + 1'b1;
              w_state    = SCAN;
            end else begin
              w_rel_cnt  = r_rel_cnt + 1'b1;
            end
          end
        end

        default: w_state = SCAN;
      endcase
    end

    if (w_accept) begin
      w_key_code  = {w_row, r_col};
      w_key_valid = 1'b1;
      w_key_held  = 1'b1;
      w_deb_cnt   = '0;
      w_rel_cnt   = '0;
      w_state     = HELD;
`ifdef KEYPAD_REPEAT_EN
      w_hold_cnt  = '0;
      w_repeating = 1'b0;
`endif
    end
  end

  assign col_select = COL_STROBE[r_col];
  assign key_code   = r_key_code;
  assign key_valid  = r_key_valid;
  assign key_held   = r_key_held;

endmodule

// File: tb/tb_keypad_scanner.sv
// -----------------------------------------------------------------------------
// tb_keypad_scanner
//   Self-checking bench for keypad_scanner. A keypad matrix model turns the
//   set of pressed keys into row levels from the strobed column. A reference
//   model, written in terms of sample run-lengths per scan tick, predicts
//   col_select/key_code/key_valid/key_held every clock; directed scenarios add
//   fixed expectations, then random press/release/reset traffic follows.
//   Build with +define+KEYPAD_REPEAT_EN to cover auto-repeat as well.
// -----------------------------------------------------------------------------
module tb_keypad_scanner;

  localparam int OVF = 3;
  localparam int DEB = 3;
  localparam int RD  = 8;
  localparam int RP  = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] row_n;
  logic [3:0] col_select;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  // keys[r*4+c] = 1 when the key at row r, column c is pressed
  logic [15:0] keys;

  int n_checks = 0;
  int n_fail   = 0;
  int n_pulses = 0;
  int cyc      = 0;

  // Reference model state
  int         m_cnt, m_col, m_cand, m_low_run, m_high_run, m_hold_ticks;
  logic [3:0] m_sync1, m_rows, m_code;
  bit         m_valid, m_held;

  always #5 clk = ~clk;

  keypad_scanner #(
    .SCAN_OVERFLOW  (OVF),
`ifdef KEYPAD_REPEAT_EN
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP),
`endif
    .DEBOUNCE_TICKS (DEB)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .row_n      (row_n),
    .col_select (col_select),
    .key_code   (key_code),
    .key_valid  (key_valid),
    .key_held   (key_held)
  );

  function automatic logic [3:0] strobe_of(input int c);
    logic [3:0] s;
    s = 4'b1111;
    s[c % 4] = 1'b0;
    return s;
  endfunction

  // Row r reads low when any pressed key in row r sits on a strobed column.
  function automatic logic [3:0] matrix(input logic [15:0] k, input logic [3:0] strobe_n);
    logic [3:0] r_n;
    for (int r = 0; r < 4; r++) r_n[r] = ~|(k[r*4 +: 4] & ~strobe_n);
    return r_n;
  endfunction

  assign row_n = matrix(keys, col_select);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_accept();
    m_code       = {2'(m_cand), 2'(m_col)};
    m_valid      = 1'b1;
    m_held       = 1'b1;
    m_high_run   = 0;
    m_hold_ticks = 0;
  endtask

  // One clock of the reference model, using the inputs present before the edge.
  task automatic model_step();
    logic [3:0] seen;
    bit         tick;
    if (reset) begin
      m_cnt = 0; m_col = 0; m_sync1 = 4'hF; m_rows = 4'hF; m_code = 4'h0;
      m_valid = 1'b0; m_held = 1'b0; m_cand = -1;
      m_low_run = 0; m_high_run = 0; m_hold_ticks = 0;
      return;
    end
    tick    = (m_cnt == OVF);
    seen    = m_rows;
    m_rows  = m_sync1;
    m_sync1 = matrix(keys, strobe_of(m_col));
    m_cnt   = tick ? 0 : m_cnt + 1;
    m_valid = 1'b0;
    if (!tick) return;

    if (m_cand < 0) begin
      if (seen != 4'hF) begin
        for (int r = 3; r >= 0; r--) if (!seen[r]) m_cand = r;
        m_low_run = 1;
        if (m_low_run >= DEB) model_accept();
      end else begin
        m_col = (m_col + 1) % 4;
      end
    end else if (!m_held) begin
      if (!seen[m_cand]) begin
        m_low_run++;
        if (m_low_run == DEB) model_accept();
      end else begin
        m_cand = -1;
        m_col  = (m_col + 1) % 4;
      end
    end else begin
      if (seen[m_cand]) begin
        m_high_run++;
        m_hold_ticks = 0;
        if (m_high_run == DEB) begin
          m_held = 1'b0;
          m_cand = -1;
          m_col  = (m_col + 1) % 4;
        end
      end else begin
        m_high_run = 0;
        m_hold_ticks++;
`ifdef KEYPAD_REPEAT_EN
        if (m_hold_ticks >= RD && (m_hold_ticks - RD) % RP == 0) m_valid = 1'b1;
`endif
      end
    end
  endtask

  // Advance one clock; compare every output against the model on the falling edge.
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    cyc++;
    check("col_select", 32'(col_select), 32'(strobe_of(m_col)));
    check("key_code",   32'(key_code),   32'(m_code));
    check("key_valid",  32'(key_valid),  32'(m_valid));
    check("key_held",   32'(key_held),   32'(m_held));
    if (key_valid === 1'b1) n_pulses++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic wait_held(input bit level, input string tag);
    for (int i = 0; i < 120 && key_held !== level; i++) cycle();
    check(tag, 32'(key_held), 32'(level));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_col"},   32'(col_select), 32'h0000000E);
    check({tag, "_code"},  32'(key_code),   32'h0);
    check({tag, "_valid"}, 32'(key_valid),  32'h0);
    check({tag, "_held"},  32'(key_held),   32'h0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int q_off[$];
    int c0;
    reset = 1'b1;
    keys  = '0;
    run(3);
    check_reset_outputs("reset");
    reset = 1'b0;

    // 1: idle scanning for 40 clocks -> ten ticks, column index 2
    n_pulses = 0;
    run(40);
    check("idle_col", 32'(col_select), 32'hB);
    check("idle_pulses", 32'(n_pulses), 32'h0);

    // 2: key row1/col2 -> single event with code 0110, column frozen
    n_pulses = 0;
    keys[1*4+2] = 1'b1;
    run(48);
    check("press_code", 32'(key_code), 32'h6);
    check("press_held", 32'(key_held), 32'h1);
    check("press_col", 32'(col_select), 32'hB);
    check("press_pulses", 32'(n_pulses), 32'h1);

    // 4a: release -> held drops after three high ticks, scan resumes at col3
    n_pulses = 0;
    keys = '0;
    wait_held(1'b0, "release_drop");
    check("release_col", 32'(col_select), 32'h7);
    check("release_pulses", 32'(n_pulses), 32'h0);

    // 4b: one-tick release glitch keeps the key held, no new event
    keys[1*4+2] = 1'b1;
    wait_held(1'b1, "reheld");
    n_pulses = 0;
    keys = '0;
    run(4);
    keys[1*4+2] = 1'b1;
    run(20);
    check("glitch_held", 32'(key_held), 32'h1);
    check("glitch_pulses", 32'(n_pulses), 32'h0);
    keys = '0;
    wait_held(1'b0, "glitch_release");
    run(8);

    // 3: bounce - row0/col0 low for a single tick window
    n_pulses = 0;
    keys[0] = 1'b1;
    run(4);
    keys = '0;
    run(24);
    check("bounce_pulses", 32'(n_pulses), 32'h0);
    check("bounce_held", 32'(key_held), 32'h0);

    // 5: rows 0 and 3 on col1 -> row 0 wins; extra key while held is ignored
    keys[0*4+1] = 1'b1;
    keys[3*4+1] = 1'b1;
    wait_held(1'b1, "multi_held");
    check("multi_code", 32'(key_code), 32'h1);
    n_pulses = 0;
    keys[2*4+2] = 1'b1;
    run(20);
    check("second_key_pulses", 32'(n_pulses), 32'h0);
    check("second_key_code", 32'(key_code), 32'h1);
    keys = '0;
    wait_held(1'b0, "multi_release");
    run(8);

    // 6: reset during DEBOUNCE and during HELD
    keys[2*4+3] = 1'b1;
    for (int i = 0; i < 80 && !(m_cand >= 0 && !m_held); i++) cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check_reset_outputs("rst_debounce");
    wait_held(1'b1, "rst_reheld");
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check_reset_outputs("rst_held");

`ifdef KEYPAD_REPEAT_EN
    // auto-repeat: pulses 8,12,16,20 ticks after the accept pulse
    for (int i = 0; i < 120 && key_valid !== 1'b1; i++) cycle();
    check("repeat_accept", 32'(key_valid), 32'h1);
    c0 = cyc;
    for (int i = 0; i < 81; i++) begin
      cycle();
      if (key_valid === 1'b1) q_off.push_back(cyc - c0);
    end
    check("repeat_count", 32'(q_off.size()), 32'h4);
    for (int i = 0; i < 4; i++) begin
      check("repeat_offset", 32'((i < q_off.size()) ? q_off[i] : -1), 32'(32 + 16 * i));
    end
`endif
    keys = '0;
    run(24);

    // Random traffic: 0, 1 or 2 keys held for random durations, rare resets
    for (int it = 0; it < 300; it++) begin
      int pick;
      pick = $urandom_range(0, 3);
      keys = '0;
      if (pick >= 1) keys[$urandom_range(0, 15)] = 1'b1;
      if (pick == 3) keys[$urandom_range(0, 15)] = 1'b1;
      if ($urandom_range(0, 39) == 0) reset = 1'b1;
      cycle();
      reset = 1'b0;
      run($urandom_range(1, 50));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
